ercm_prod_accum: RTL and testbench
==================================

// Module: ercm_prod_accum
// PURPOSE
//  Downstream consumer of the 8x8 approximate multiplier (16-bit product). Applies a signed
//  error-bias correction to each product, clamps to the 16-bit range and accumulates a frame
//  of FRM products into a saturating sum. Handshakes: valid/ready on the input, valid/ready on the result.
// PARAMETERS
//  ACC_W    24   accumulator/result width in bits (>= 17)
//  CNT_W    8    frame-length counter width; max frame length is 2^CNT_W-1
//  BIAS_W   8    width of the signed bias-correction input
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  clr          in   1       synchronous abort: drop partial frame, return to IDLE
//  frm_len      in   CNT_W   products per frame; sampled on the first accepted beat of a frame
//  bias         in   BIAS_W  signed correction added to every product; sampled with frm_len
//  dat_in       in   16      approximate product from the multiplier stage
//  dat_in_vld   in   1       dat_in valid
//  dat_in_rdy   out  1       block can accept dat_in this cycle
//  dat_o        out  ACC_W   frame sum (saturated)
//  dat_o_vld    out  1       dat_o valid; held until consumed
//  dat_o_rdy    in   1       downstream accepts dat_o
//  ovf_o        out  1       accumulator saturated during this frame; valid with dat_o_vld
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, acc=0, cnt=0, dat_o=0, dat_o_vld=0, ovf_o=0, dat_in_rdy=0
//   while rst is asserted; dat_in_rdy=1 from the first clock after release.
//  Beat accepted when dat_in_vld & dat_in_rdy. Corrected product:
//   p = clamp(zext(dat_in) + sext(bias_latched), 0, 65535); computed in 18-bit signed.
//  States:
//   IDLE: dat_in_rdy=1. On accept: latch frm_len (0 is treated as 1) and bias, acc=p, cnt=1;
//         go HOLD if latched length==1, else ACC.
//   ACC:  dat_in_rdy=1. On accept: acc=sat(acc+p), cnt+=1; when cnt reaches length -> HOLD.
//         The first beat of IDLE uses the live bias; later beats use the latched bias.
//   HOLD: dat_in_rdy=0, dat_o_vld=1, dat_o=acc, ovf_o=sticky overflow flag.
//         On dat_o_rdy: dat_o_vld=0 next cycle, acc/cnt/ovf cleared, -> IDLE.
//  Latency: last beat accepted in cycle T -> dat_o_vld=1 in T+1. Throughput: one beat/cycle
//   inside a frame; one bubble cycle per frame (HOLD) minimum.
//  Saturation: acc+p > 2^ACC_W-1 -> acc=2^ACC_W-1, ovf set and held for the rest of the frame.
//  dat_o and ovf_o are stable while dat_o_vld=1 and dat_o_rdy=0. Changes to frm_len or bias
//   mid-frame have no effect.
//  clr: has priority over all other events in the same cycle, including accept and dat_o_rdy.
//   Next cycle: IDLE, acc=0, cnt=0, dat_o_vld=0, ovf_o=0. A beat presented with clr is dropped.
//  dat_in_vld in HOLD is not accepted. In the cycle dat_o_rdy releases HOLD, no input is
//   taken; the next frame's first beat can be accepted one cycle later.
//  Counter wrap is impossible: cnt stops at length (<= 2^CNT_W-1).
//  All outputs are registered except dat_in_rdy, which is a decode of the state register.
// STRUCTURE
//  Shared package: PROD_W=16; the state encoding (IDLE=2'd0, ACC=2'd1, HOLD=2'd2);
//   the saturation-max constant function for ACC_W.
//  One sub-module: ercm_bias_clamp. It is combinational: 16-bit product + signed bias ->
//   clamped 16-bit value. It is reused by the other multiplier variants' accumulators.
//  Top level: state register, counter, accumulator with saturating adder, and output holding
//   registers.
// TESTING
//  1. frm_len=4, bias=0, dat_in=100,200,300,400 back-to-back -> dat_o=1000, ovf_o=0,
//     dat_o_vld one cycle after the 4th accept.
//  2. frm_len=2, bias=-5, dat_in=3,10 -> p=0,5; dat_o=5. With bias=+10 and dat_in=65530
//     twice -> p=65535 each; dat_o=131070.
//  3. ACC_W=17, frm_len=3, dat_in=65535 x3 -> dat_o=131071, ovf_o=1. The next frame starts
//     with ovf_o=0.
//  4. Hold dat_o_rdy=0 for 5 cycles in HOLD while dat_in_vld=1 -> dat_in_rdy=0, dat_o stable.
//     Raise dat_o_rdy -> IDLE, and the next beat is accepted two cycles later.
//  5. Assert clr mid-frame after 2 of 4 beats, then start a new frame with 4x1 -> dat_o=4.
//     clr and dat_o_rdy asserted together in HOLD -> dat_o_vld=0, acc=0.
//  6. Assert async rst mid-frame, between clock edges -> all outputs 0 immediately.
//     frm_len=0 with a single beat of 7 -> dat_o=7 after one cycle.

Source files
------------

// File: rtl/ercm_prod_accum_pkg.sv
// Shared definitions for the approximate-multiplier product accumulators:
// product width, FSM encoding and the saturation ceiling helper.
package ercm_prod_accum_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // All-ones value of a w-bit unsigned accumulator, usable in constant context.
  function automatic logic [63:0] sat_max(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/ercm_prod_accum_if.sv
// Product-in / frame-sum-out bus of the product accumulator, including the
// frame controls (clr, frm_len, bias) that travel with the input stream.
interface ercm_prod_accum_if #(
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8,
  parameter int BIAS_W = 8
);
  import ercm_prod_accum_pkg::*;

  logic                     clr;
  logic [CNT_W-1:0]         frm_len;
  logic signed [BIAS_W-1:0] bias;
  logic [PROD_W-1:0]        dat_in;
  logic                     dat_in_vld;
  logic                     dat_in_rdy;
  logic [ACC_W-1:0]         dat_o;
  logic                     dat_o_vld;
  logic                     dat_o_rdy;
  logic                     ovf_o;

  // Producer / result consumer side.
  modport master (
    output clr, frm_len, bias, dat_in, dat_in_vld, dat_o_rdy,
    input  dat_in_rdy, dat_o, dat_o_vld, ovf_o
  );

  // Accumulator side.
  modport slave (
    input  clr, frm_len, bias, dat_in, dat_in_vld, dat_o_rdy,
    output dat_in_rdy, dat_o, dat_o_vld, ovf_o
  );

endinterface

// File: rtl/ercm_bias_clamp.sv
// Combinational bias correction: unsigned product plus signed bias, clamped
// back into the unsigned product range.
module ercm_bias_clamp
  import ercm_prod_accum_pkg::*;
#(
  parameter int BIAS_W = 8
) (
  input  logic [PROD_W-1:0]        prod_i,
  input  logic signed [BIAS_W-1:0] bias_i,
  output logic [PROD_W-1:0]        prod_o
);

  localparam int SUM_W = PROD_W + 2;

  logic [SUM_W-1:0] bias_ext;
  logic [SUM_W-1:0] sum;

  // Two headroom bits: bit SUM_W-1 is the sign, bit PROD_W flags overshoot.
  always_comb begin
    bias_ext = {{(SUM_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    sum      = {2'b00, prod_i} + bias_ext;
    if (sum[SUM_W-1])
      prod_o = '0;
    else if (sum[PROD_W])
      prod_o = '1;
    else
      prod_o = sum[PROD_W-1:0];
  end

endmodule

// File: rtl/ercm_prod_accum.sv
// Frame accumulator for approximate products: bias-corrects each beat, sums a
// frame of frm_len beats with saturation and holds the result until consumed.
module ercm_prod_accum
  import ercm_prod_accum_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8,
  parameter int BIAS_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  ercm_prod_accum_if.slave bus
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));

  state_e                   st_q;
  logic                     live_q;
  logic                     vld_q;
  logic                     ovf_q;
  logic                     ovf_o_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         len_q;
  logic signed [BIAS_W-1:0] bias_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         dat_o_q;

  logic [CNT_W-1:0]         cnt_d;
  logic [CNT_W-1:0]         len_d;
  logic [ACC_W-1:0]         acc_d;
  logic                     ovf_d;
  logic                     last_d;
  logic signed [BIAS_W-1:0] bias_sel;
  logic [PROD_W-1:0]        prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W:0]           sum;
  logic                     sat;
  logic                     accept;

  // live_q keeps the input closed until the first clock after reset release.
  assign bus.dat_in_rdy = live_q && (st_q != ST_HOLD);
  assign accept         = bus.dat_in_vld && bus.dat_in_rdy;

  assign bus.dat_o     = dat_o_q;
  assign bus.dat_o_vld = vld_q;
  assign bus.ovf_o     = ovf_o_q;

  // The frame's first beat sees the live bias; later beats the latched copy.
  assign bias_sel = (st_q == ST_IDLE) ? bus.bias : bias_q;

  ercm_bias_clamp #(.BIAS_W(BIAS_W)) u_clamp (
    .prod_i (bus.dat_in),
    .bias_i (bias_sel),
    .prod_o (prod)
  );

  always_comb begin
    len_d    = (bus.frm_len == '0) ? CNT_W'(1) : bus.frm_len;
    prod_ext = ACC_W'(prod);
    sum      = {1'b0, acc_q} + {1'b0, prod_ext};
    sat      = sum[ACC_W];
    if (st_q == ST_IDLE) begin
      acc_d  = prod_ext;
      cnt_d  = CNT_W'(1);
      ovf_d  = 1'b0;
      last_d = (len_d == CNT_W'(1));
    end else begin
      acc_d  = sat ? ACC_MAX : sum[ACC_W-1:0];
      cnt_d  = cnt_q + CNT_W'(1);
      ovf_d  = ovf_q | sat;
      last_d = (cnt_d == len_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      live_q  <= 1'b0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ovf_o_q <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      dat_o_q <= '0;
    end else begin
      live_q <= 1'b1;
      // clr outranks a beat and a result handshake arriving in the same cycle.
      if (bus.clr) begin
        st_q    <= ST_IDLE;
        vld_q   <= 1'b0;
        ovf_q   <= 1'b0;
        ovf_o_q <= 1'b0;
        cnt_q   <= '0;
        acc_q   <= '0;
        dat_o_q <= '0;
      end else begin
        case (st_q)
          ST_IDLE, ST_ACC: begin
            if (accept) begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
              if (st_q == ST_IDLE) begin
                len_q  <= len_d;
                bias_q <= bus.bias;
              end
              if (last_d) begin
                st_q    <= ST_HOLD;
                vld_q   <= 1'b1;
                dat_o_q <= acc_d;
                ovf_o_q <= ovf_d;
              end else begin
                st_q <= ST_ACC;
              end
            end
          end
          ST_HOLD: begin
            if (bus.dat_o_rdy) begin
              st_q    <= ST_IDLE;
              vld_q   <= 1'b0;
              ovf_q   <= 1'b0;
              ovf_o_q <= 1'b0;
              cnt_q   <= '0;
              acc_q   <= '0;
              dat_o_q <= '0;
            end
          end
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (vld_q && !bus.dat_o_rdy && !bus.clr) |=> (vld_q && $stable(dat_o_q) && $stable(ovf_o_q)));

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    (st_q != ST_IDLE) |-> (cnt_q <= len_q));

endmodule

// File: tb/tb_ercm_prod_accum.sv
// Scoreboard bench for ercm_prod_accum: expected frame sums are queued as
// beats are driven and popped when a result handshake completes.
module tb_ercm_prod_accum;
  import ercm_prod_accum_pkg::*;

  localparam int ACC_W  = 17;
  localparam int CNT_W  = 8;
  localparam int BIAS_W = 8;

  typedef struct {
    logic [ACC_W-1:0] dat;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  ercm_prod_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W), .BIAS_W(BIAS_W)) bus ();

  ercm_prod_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W), .BIAS_W(BIAS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.clr        = 1'b0;
    bus.frm_len    = '0;
    bus.bias       = '0;
    bus.dat_in     = '0;
    bus.dat_in_vld = 1'b0;
    bus.dat_o_rdy  = 1'b0;
  endtask

  // Present one beat and return #1 after the edge that accepted it.
  task automatic send(input logic [15:0] d, input logic [CNT_W-1:0] len,
                      input logic signed [BIAS_W-1:0] b);
    int t;
    t = 0;
    bus.dat_in = d; bus.frm_len = len; bus.bias = b; bus.dat_in_vld = 1'b1;
    @(negedge clk);
    while (bus.dat_in_rdy !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: dat_in_rdy=%b required 1", bus.dat_in_rdy);
    end
    @(posedge clk); #1;
    bus.dat_in_vld = 1'b0;
  endtask

  // Complete one result handshake; hand back observed values and the queued expectation.
  task automatic take(output exp_t e, output logic [ACC_W-1:0] d, output logic o);
    int t;
    t = 0;
    while (bus.dat_o_vld !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL result_timeout: dat_o_vld=%b required 1", bus.dat_o_vld);
    end
    bus.dat_o_rdy = 1'b1;
    @(negedge clk);
    d = bus.dat_o;
    o = bus.ovf_o;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: unexpected result %0d", d);
      e.dat = 'x; e.ovf = 1'bx;
    end else begin
      e = sb.pop_front();
    end
    @(posedge clk); #1;
    bus.dat_o_rdy = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.dat_o !== '0 || bus.dat_o_vld !== 1'b0 || bus.ovf_o !== 1'b0 || bus.dat_in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: dat_o=%0d vld=%b ovf=%b rdy=%b required 0 0 0 0",
               bus.dat_o, bus.dat_o_vld, bus.ovf_o, bus.dat_in_rdy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.dat_in_rdy !== 1'b0) begin
      n_err++; $display("FAIL rdy_before_clock: dat_in_rdy=%b required 0", bus.dat_in_rdy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.dat_in_rdy !== 1'b1) begin
      n_err++; $display("FAIL rdy_after_release: dat_in_rdy=%b required 1", bus.dat_in_rdy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [ACC_W-1:0] d; logic o;
    sb.push_back('{dat: 17'd1000, ovf: 1'b0});
    send(16'd100, 8'd4, 8'sd0);
    send(16'd200, 8'd4, 8'sd0);
    send(16'd300, 8'd4, 8'sd0);
    n_cmp++;
    if (bus.dat_o_vld !== 1'b0) begin
      n_err++; $display("FAIL early_valid: dat_o_vld=%b required 0", bus.dat_o_vld);
    end
    send(16'd400, 8'd4, 8'sd0);
    n_cmp++;
    if (bus.dat_o_vld !== 1'b1) begin
      n_err++; $display("FAIL latency: dat_o_vld=%b required 1", bus.dat_o_vld);
    end
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL sum_1000: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
  endtask

  task automatic test_bias();
    exp_t e; logic [ACC_W-1:0] d; logic o;
    // Second beat carries different frm_len/bias: latched values must win.
    sb.push_back('{dat: 17'd5, ovf: 1'b0});
    send(16'd3,  8'd2, -8'sd5);
    send(16'd10, 8'd9, 8'sd77);
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL bias_neg: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
    sb.push_back('{dat: 17'd131070, ovf: 1'b0});
    send(16'd65530, 8'd2, 8'sd10);
    send(16'd65530, 8'd2, -8'sd100);
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL bias_clamp_hi: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
  endtask

  task automatic test_saturation();
    exp_t e; logic [ACC_W-1:0] d; logic o;
    sb.push_back('{dat: 17'd131071, ovf: 1'b1});
    for (int i = 0; i < 3; i++) send(16'd65535, 8'd3, 8'sd0);
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL saturate: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
    sb.push_back('{dat: 17'd5, ovf: 1'b0});
    send(16'd5, 8'd1, 8'sd0);
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL ovf_cleared: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
  endtask

  task automatic test_hold();
    exp_t e; logic [ACC_W-1:0] d; logic o;
    sb.push_back('{dat: 17'd42, ovf: 1'b0});
    send(16'd42, 8'd1, 8'sd0);
    bus.dat_in = 16'd9; bus.frm_len = 8'd1; bus.bias = 8'sd0; bus.dat_in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.dat_in_rdy !== 1'b0 || bus.dat_o_vld !== 1'b1 || bus.dat_o !== 17'd42) begin
        n_err++;
        $display("FAIL hold_stable: rdy=%b vld=%b dat_o=%0d required 0 1 42",
                 bus.dat_in_rdy, bus.dat_o_vld, bus.dat_o);
      end
    end
    @(posedge clk); #1;
    bus.dat_o_rdy = 1'b1;
    sb.push_back('{dat: 17'd9, ovf: 1'b0});
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (bus.dat_o !== e.dat || bus.ovf_o !== e.ovf || bus.dat_in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: got %0d/%b rdy=%b required %0d/%b rdy=0",
               bus.dat_o, bus.ovf_o, bus.dat_in_rdy, e.dat, e.ovf);
    end
    @(posedge clk); #1;
    bus.dat_o_rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.dat_in_rdy !== 1'b1 || bus.dat_o_vld !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_release: rdy=%b vld=%b required 1 0", bus.dat_in_rdy, bus.dat_o_vld);
    end
    @(posedge clk); #1;
    bus.dat_in_vld = 1'b0;
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL beat_after_hold: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
  endtask

  task automatic test_clr();
    exp_t e; logic [ACC_W-1:0] d; logic o;
    send(16'd50, 8'd4, 8'sd0);
    send(16'd60, 8'd4, 8'sd0);
    bus.clr = 1'b1; bus.dat_in = 16'd999; bus.dat_in_vld = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0; bus.dat_in_vld = 1'b0;
    n_cmp++;
    if (bus.dat_o_vld !== 1'b0 || bus.dat_in_rdy !== 1'b1 || bus.ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL clr_mid_frame: vld=%b rdy=%b ovf=%b required 0 1 0",
               bus.dat_o_vld, bus.dat_in_rdy, bus.ovf_o);
    end
    sb.push_back('{dat: 17'd4, ovf: 1'b0});
    for (int i = 0; i < 4; i++) send(16'd1, 8'd4, 8'sd0);
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL frame_after_clr: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
    // Result dropped by clr racing dat_o_rdy: nothing queued for it.
    send(16'd33, 8'd1, 8'sd0);
    bus.clr = 1'b1; bus.dat_o_rdy = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0; bus.dat_o_rdy = 1'b0;
    n_cmp++;
    if (bus.dat_o_vld !== 1'b0 || bus.dat_o !== '0 || bus.ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL clr_in_hold: vld=%b dat_o=%0d ovf=%b required 0 0 0",
               bus.dat_o_vld, bus.dat_o, bus.ovf_o);
    end
  endtask

  task automatic test_async_reset();
    exp_t e; logic [ACC_W-1:0] d; logic o;
    send(16'd11, 8'd4, 8'sd0);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.dat_in_rdy !== 1'b0) begin
      n_err++; $display("FAIL async_rst_rdy: dat_in_rdy=%b required 0", bus.dat_in_rdy);
    end
    @(posedge clk); #1 rst = 1'b0;
    send(16'd77, 8'd1, 8'sd0);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.dat_o !== '0 || bus.dat_o_vld !== 1'b0 || bus.ovf_o !== 1'b0 || bus.dat_in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst_hold: dat_o=%0d vld=%b ovf=%b rdy=%b required 0 0 0 0",
               bus.dat_o, bus.dat_o_vld, bus.ovf_o, bus.dat_in_rdy);
    end
    @(posedge clk); #1 rst = 1'b0;
    sb.push_back('{dat: 17'd7, ovf: 1'b0});
    send(16'd7, 8'd0, 8'sd0);
    n_cmp++;
    if (bus.dat_o_vld !== 1'b1) begin
      n_err++; $display("FAIL len0_latency: dat_o_vld=%b required 1", bus.dat_o_vld);
    end
    take(e, d, o);
    n_cmp++;
    if (d !== e.dat || o !== e.ovf) begin
      n_err++; $display("FAIL len0_single: got %0d/%b required %0d/%b", d, o, e.dat, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bias();
    test_saturation();
    test_hold();
    test_clr();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
